// File: rtl/host_d500_pkg.sv
// host_d500_pkg: register map, bit positions and entry layout shared by the
// Atari $D5xx capture block and its queue.
package host_d500_pkg;
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_TSTAMP = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;
   localparam int DATA_VALID_BIT = 31;
   localparam int DATA_RW_BIT    = 16;
   localparam int ST_OVF_BIT     = 8;
   localparam int ST_IRQEN_BIT   = 9;
   localparam int CTRL_FLUSH_BIT = 0;
   localparam int ENTRY_W        = 17;
   localparam int TS_W           = 16;
   typedef struct packed {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] data;
   } entry_t;
endpackage

// File: rtl/host_d500_fifo.sv
// host_d500_fifo: power-of-two capture queue with push, pop and a one-clock
// flush that overrides both.
module host_d500_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 17,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  logic [W-1:0]  din_i,
   output logic [W-1:0]  dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          do_push, do_pop;

   assign full_o  = lvl_q == LW'(DEPTH);
   assign empty_o = lvl_q == '0;
   assign level_o = lvl_q;
   assign dout_o  = mem_q[rd_q];
   // a pop frees the slot a push into a full queue needs in the same clock
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & (~full_o | pop_i) & ~flush_i;

   always_comb begin
      wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
      rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
      lvl_d = flush_i ? '0 : lvl_q + LW'(do_push) - LW'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end

   always_ff @(posedge clk)
      if (do_push) mem_q[wr_q] <= din_i;
endmodule

// File: rtl/host_d500_capture.sv
// host_d500_capture: queues Atari $D5xx accesses for an Avalon-MM host.
// Define HOST_D500_TIMESTAMP_EN to store a 16-bit clock timestamp per entry.
module host_d500_capture
   import host_d500_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        atari_strobe,
   input  logic [7:0]  atari_addr,
   input  logic [7:0]  atari_data,
   input  logic        atari_rw,
   input  logic [1:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq
);
`ifdef HOST_D500_TIMESTAMP_EN
   localparam int EW = ENTRY_W + TS_W;
`else
   localparam int EW = ENTRY_W;
`endif
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [SYNC_STAGES-1:0] sync_q, vld_q;
   logic [SYNC_STAGES:0]   sync_chain, vld_chain;
   logic                   prev_q, pv_q, ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q;
   logic [31:0]            rdata_q, rdata_d, data_w, stat_w, ts_w;
   logic                   capture, pop, flush, wr_stat, full, empty, unused_ok;
   logic [LW-1:0]          level;
   logic [EW-1:0]          din, dout;
   entry_t                 head;

   assign sync_chain = {sync_q, atari_strobe};
   assign vld_chain  = {vld_q, 1'b1};
   // vld_q tracks which stages hold a post-reset sample, so a strobe already
   // high at reset release never looks like a rising edge
   assign capture    = sync_q[SYNC_STAGES-1] & ~prev_q & pv_q;
   assign pop        = read & (address == REG_DATA);
   assign wr_stat    = write & (address == REG_STATUS);
   assign flush      = write & (address == REG_CTRL) & writedata[CTRL_FLUSH_BIT];
   assign head       = dout[ENTRY_W-1:0];
   assign readdata   = rdata_q;
   assign irq        = irq_q;
   assign unused_ok  = ^{writedata[31:10], writedata[7:1], sync_chain[SYNC_STAGES], vld_chain[SYNC_STAGES]};

`ifdef HOST_D500_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ts_q <= '0;
      else ts_q <= ts_q + 1'b1;
   assign din  = {ts_q, atari_rw, atari_addr, atari_data};
   assign ts_w = empty ? '0 : 32'(dout[EW-1:ENTRY_W]);
`else
   assign din  = {atari_rw, atari_addr, atari_data};
   assign ts_w = '0;
`endif

   host_d500_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (capture),
      .pop_i   (pop),
      .flush_i (flush),
      .din_i   (din),
      .dout_o  (dout),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   always_comb begin
      data_w   = empty ? '0 : (32'(head) | (32'd1 << DATA_VALID_BIT));
      stat_w   = 32'(level) | (32'(ovf_q) << ST_OVF_BIT) | (32'(irq_en_q) << ST_IRQEN_BIT);
      rdata_d  = address == REG_DATA   ? data_w :
                 address == REG_STATUS ? stat_w :
                 address == REG_TSTAMP ? ts_w   : '0;
      // a dropped push sets overflow even when the host clears it that clock
      ovf_d    = (capture & full & ~pop & ~flush) | (ovf_q & ~(wr_stat & writedata[ST_OVF_BIT]));
      irq_en_d = wr_stat ? writedata[ST_IRQEN_BIT] : irq_en_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync_q   <= '0;
         vld_q    <= '0;
         prev_q   <= 1'b0;
         pv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         sync_q   <= sync_chain[SYNC_STAGES-1:0];
         vld_q    <= vld_chain[SYNC_STAGES-1:0];
         prev_q   <= sync_q[SYNC_STAGES-1];
         pv_q     <= vld_q[SYNC_STAGES-1];
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_q & ~empty;
         rdata_q  <= rdata_d;
      end
endmodule
